// File: rtl/serial_pkg.sv
// Definitions shared by the serializer / deserializer pair: default frame
// width, bit ordering and the FSM state encoding.
package serial_pkg;

  localparam int DATA_WIDTH        = 8;
  localparam bit MSB_FIRST_DEFAULT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial2parallel.sv
// Deserializer: assembles a WIDTH-bit word from a 1-bit serial line starting on
// an en strobe, pulses valid when complete and abort when a frame is cut short.
module serial2parallel
  import serial_pkg::*;
#(
  parameter int WIDTH     = DATA_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             abort
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             abort_reg;

  // After WIDTH shifts the first bit sits at the MSB (MSB_FIRST) or the LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic             bit_in);
    if (MSB_FIRST)
      return {word[WIDTH-2:0], bit_in};
    else
      return {bit_in, word[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      abort_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            shift_reg <= shift_in('0, data_in);
            cnt_reg   <= CNT_ONE;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            // A new start wins over the frame in flight, even on its last bit.
            abort_reg <= 1'b1;
            shift_reg <= shift_in('0, data_in);
            cnt_reg   <= CNT_ONE;
          end else if (cnt_reg == CNT_LAST) begin
            data_out_reg <= shift_in(shift_reg, data_in);
            valid_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= IDLE;
          end else begin
            shift_reg <= shift_in(shift_reg, data_in);
            cnt_reg   <= cnt_reg + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign data_out = data_out_reg;
  assign valid    = valid_reg;
  assign busy     = busy_reg;
  assign abort    = abort_reg;

endmodule

// File: tb/tb_serial2parallel.sv
// Drives one serial stream into an MSB-first and an LSB-first deserializer and
// checks both against a bit-level frame model through a scoreboard.
module tb_serial2parallel;

  logic       clk;
  logic       rst;
  logic       en;
  logic       data_in;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic       busy_m, busy_l;
  logic       abort_m, abort_l;

  serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .data_out(data_m), .valid(valid_m), .busy(busy_m), .abort(abort_m)
  );

  serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .data_out(data_l), .valid(valid_l), .busy(busy_l), .abort(abort_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wm;
    logic [7:0] wl;
    int         due;
  } exp_t;

  exp_t       sb_q[$];
  int         ab_q[$];
  bit         busy_exp[int];
  logic [7:0] last_m, last_l;
  logic       fb[8];
  int         nb;
  int         edge_cnt;
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, edge_cnt);
  endtask

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  // Drives one bit for the next edge and advances the frame model.
  task automatic drive_bit(input logic e, input logic d);
    int   k;
    exp_t x;
    @(posedge clk);
    #1;
    en      = e;
    data_in = d;
    k       = edge_cnt + 1;
    if (e) begin
      if (nb > 0) ab_q.push_back(k);
      nb = 0;
    end
    if (e || nb > 0) begin
      fb[nb] = d;
      nb++;
      if (nb == 8) begin
        for (int i = 0; i < 8; i++) begin
          x.wm[7-i] = fb[i];
          x.wl[i]   = fb[i];
        end
        x.due = k;
        sb_q.push_back(x);
        nb          = 0;
        busy_exp[k] = 1'b0;
      end else begin
        busy_exp[k] = 1'b1;
      end
    end else begin
      busy_exp[k] = 1'b0;
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit msb);
    logic [7:0] v;
    v = w;
    for (int i = 0; i < 8; i++)
      drive_bit(i == 0, msb ? v[7-i] : v[i]);
  endtask

  task automatic send_partial(input logic [7:0] w, input int n);
    logic [7:0] v;
    v = w;
    for (int i = 0; i < n; i++)
      drive_bit(i == 0, v[7-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive_bit(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data_m"},  32'(data_m),  32'h0);
    check({tag, "_data_l"},  32'(data_l),  32'h0);
    check({tag, "_valid_m"}, 32'(valid_m), 32'h0);
    check({tag, "_valid_l"}, 32'(valid_l), 32'h0);
    check({tag, "_busy_m"},  32'(busy_m),  32'h0);
    check({tag, "_busy_l"},  32'(busy_l),  32'h0);
    check({tag, "_abort_m"}, 32'(abort_m), 32'h0);
  endtask

  // Raises rst between edges and checks the outputs before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check_reset_state("rst_mid");
    nb     = 0;
    last_m = '0;
    last_l = '0;
    sb_q.delete();
    ab_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares both DUTs against the model once per cycle.
  initial begin
    logic ev, ea;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ev = (sb_q.size() > 0) && (sb_q[0].due == edge_cnt);
        check("valid_m", 32'(valid_m), 32'(ev));
        check("valid_l", 32'(valid_l), 32'(ev));
        if (ev) begin
          last_m = sb_q[0].wm;
          last_l = sb_q[0].wl;
          void'(sb_q.pop_front());
          $display("frame at edge %0d: msb-first %02h lsb-first %02h", edge_cnt, data_m, data_l);
        end
        check("data_m", 32'(data_m), 32'(last_m));
        check("data_l", 32'(data_l), 32'(last_l));
        ea = (ab_q.size() > 0) && (ab_q[0] == edge_cnt);
        if (ea) void'(ab_q.pop_front());
        check("abort_m", 32'(abort_m), 32'(ea));
        check("abort_l", 32'(abort_l), 32'(ea));
        if (busy_exp.exists(edge_cnt)) begin
          check("busy_m", 32'(busy_m), 32'(busy_exp[edge_cnt]));
          check("busy_l", 32'(busy_l), 32'(busy_exp[edge_cnt]));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nb       = 0;
    last_m   = '0;
    last_l   = '0;
    rst      = 1'b1;
    en       = 1'b0;
    data_in  = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    check_reset_state("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    idle(3);
    send_word(8'hA5, 1'b1);          // stream 1,0,1,0,0,1,0,1
    idle(3);
    send_word(8'h36, 1'b0);          // stream 0,1,1,0,1,1,0,0
    idle(2);
    send_word(8'hA5, 1'b1);          // back-to-back, no gap
    send_word(8'h36, 1'b1);
    idle(3);
    send_partial(8'hC3, 4);          // en again on the 5th bit
    send_word(8'h3C, 1'b1);
    idle(2);
    send_partial(8'h5A, 7);          // en again on the last bit
    send_word(8'h81, 1'b1);
    idle(2);
    send_partial(8'h96, 4);
    do_reset();
    send_word(8'hFF, 1'b1);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      send_word(8'($urandom_range(0, 255)), 1'b1);
      if (i % 2 == 1) idle(1);
    end
    idle(12);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    check("ab_empty", 32'(ab_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
